// File: rtl/vme_arb2.sv
// Two-master round-robin arbiter in front of a single VME-style slave port.
// Each master owns one pending slot; a single slave access is outstanding at a time, with timeout.
module vme_arb2 #(
  parameter int ADDR_HI = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [ADDR_HI:2] M0_Addr,
  input  logic [31:0]      M0_WrData,
  input  logic             M0_RdMem,
  input  logic             M0_WrMem,
  output logic [31:0]      M0_RdData,
  output logic             M0_RdDone,
  output logic             M0_WrDone,
  output logic             M0_Err,
  input  logic [ADDR_HI:2] M1_Addr,
  input  logic [31:0]      M1_WrData,
  input  logic             M1_RdMem,
  input  logic             M1_WrMem,
  output logic [31:0]      M1_RdData,
  output logic             M1_RdDone,
  output logic             M1_WrDone,
  output logic             M1_Err,
  output logic [ADDR_HI:2] VMEAddr,
  output logic [31:0]      VMEWrData,
  output logic             VMERdMem,
  output logic             VMEWrMem,
  input  logic [31:0]      VMERdData,
  input  logic             VMERdDone,
  input  logic             VMEWrDone
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state_q;
  logic [1:0]       slotValid_q;
  logic [1:0]       slotWr_q;
  logic [ADDR_HI:2] slotAddr_q [2];
  logic [31:0]      slotData_q [2];
  logic             grant_q;
  logic             lastGrant_q;
  logic             grantWr_q;
  logic [7:0]       cnt_q;
  logic [1:0]       rdDone_q;
  logic [1:0]       wrDone_q;
  logic [1:0]       err_q;
  logic [31:0]      rdData_q [2];
  logic [ADDR_HI:2] vmeAddr_q;
  logic [31:0]      vmeWrData_q;
  logic             vmeRdMem_q;
  logic             vmeWrMem_q;

  logic             grantSel_d;
  logic             matchDone_d;
  logic             timedOut_d;
  logic             complete_d;

  // Tie goes to the master not granted last; otherwise the single valid slot wins.
  always_comb begin
    grantSel_d  = (slotValid_q == 2'b11) ? ~lastGrant_q : slotValid_q[1];
    matchDone_d = grantWr_q ? VMEWrDone : VMERdDone;
    timedOut_d  = (state_q == WAIT) && !matchDone_d && (cnt_q == 8'(TIMEOUT - 1));
    complete_d  = ((state_q == ISSUE) || (state_q == WAIT)) && (matchDone_d || timedOut_d);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      slotValid_q   <= '0;
      slotWr_q      <= '0;
      slotAddr_q[0] <= '0;
      slotAddr_q[1] <= '0;
      slotData_q[0] <= '0;
      slotData_q[1] <= '0;
      grant_q       <= 1'b0;
      lastGrant_q   <= 1'b1;
      grantWr_q     <= 1'b0;
      cnt_q         <= '0;
      rdDone_q      <= '0;
      wrDone_q      <= '0;
      err_q         <= '0;
      rdData_q[0]   <= '0;
      rdData_q[1]   <= '0;
      vmeAddr_q     <= '0;
      vmeWrData_q   <= '0;
      vmeRdMem_q    <= 1'b0;
      vmeWrMem_q    <= 1'b0;
    end else begin
      rdDone_q <= '0;
      wrDone_q <= '0;
      err_q    <= '0;

      // A full slot ignores new strobes, including in its completing cycle.
      if (!slotValid_q[0] && (M0_RdMem || M0_WrMem)) begin
        slotValid_q[0] <= 1'b1;
        slotWr_q[0]    <= M0_WrMem;
        slotAddr_q[0]  <= M0_Addr;
        slotData_q[0]  <= M0_WrData;
      end
      if (!slotValid_q[1] && (M1_RdMem || M1_WrMem)) begin
        slotValid_q[1] <= 1'b1;
        slotWr_q[1]    <= M1_WrMem;
        slotAddr_q[1]  <= M1_Addr;
        slotData_q[1]  <= M1_WrData;
      end

      case (state_q)
        IDLE: begin
          if (|slotValid_q) begin
            grant_q     <= grantSel_d;
            grantWr_q   <= slotWr_q[grantSel_d];
            vmeAddr_q   <= slotAddr_q[grantSel_d];
            vmeWrData_q <= slotData_q[grantSel_d];
            vmeRdMem_q  <= !slotWr_q[grantSel_d];
            vmeWrMem_q  <= slotWr_q[grantSel_d];
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          vmeRdMem_q <= 1'b0;
          vmeWrMem_q <= 1'b0;
          cnt_q      <= '0;
          if (!complete_d) state_q <= WAIT;
        end
        WAIT:    cnt_q <= cnt_q + 8'd1;
        default: state_q <= IDLE;
      endcase

      if (complete_d) begin
        state_q              <= IDLE;
        slotValid_q[grant_q] <= 1'b0;
        lastGrant_q          <= grant_q;
        rdDone_q[grant_q]    <= !grantWr_q;
        wrDone_q[grant_q]    <= grantWr_q;
        err_q[grant_q]       <= timedOut_d;
        if (!grantWr_q) rdData_q[grant_q] <= timedOut_d ? 32'h0 : VMERdData;
      end
    end
  end

  assign M0_RdData = rdData_q[0];
  assign M1_RdData = rdData_q[1];
  assign M0_RdDone = rdDone_q[0];
  assign M1_RdDone = rdDone_q[1];
  assign M0_WrDone = wrDone_q[0];
  assign M1_WrDone = wrDone_q[1];
  assign M0_Err    = err_q[0];
  assign M1_Err    = err_q[1];
  assign VMEAddr   = vmeAddr_q;
  assign VMEWrData = vmeWrData_q;
  assign VMERdMem  = vmeRdMem_q;
  assign VMEWrMem  = vmeWrMem_q;

endmodule

// File: tb/tb_vme_arb2.sv
// Self-checking bench for vme_arb2: directed scenarios plus random traffic,
// all compared every cycle against a transaction-level model of the arbiter.
module tb_vme_arb2;
  localparam int ADDR_HI = 9;
  localparam int TIMEOUT = 15;
  localparam int AW      = ADDR_HI - 1;
  localparam int VW      = 8 + AW + 96;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [ADDR_HI:2] M0_Addr = '0, M1_Addr = '0;
  logic [31:0] M0_WrData = '0, M1_WrData = '0;
  logic M0_RdMem = 0, M0_WrMem = 0, M1_RdMem = 0, M1_WrMem = 0;
  logic [31:0] M0_RdData, M1_RdData;
  logic M0_RdDone, M0_WrDone, M0_Err, M1_RdDone, M1_WrDone, M1_Err;
  logic [ADDR_HI:2] VMEAddr;
  logic [31:0] VMEWrData;
  logic VMERdMem, VMEWrMem;
  logic [31:0] VMERdData = '0;
  logic VMERdDone = 0, VMEWrDone = 0;

  always #5 Clk = ~Clk;

  vme_arb2 #(.ADDR_HI(ADDR_HI), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst),
    .M0_Addr(M0_Addr), .M0_WrData(M0_WrData), .M0_RdMem(M0_RdMem), .M0_WrMem(M0_WrMem),
    .M0_RdData(M0_RdData), .M0_RdDone(M0_RdDone), .M0_WrDone(M0_WrDone), .M0_Err(M0_Err),
    .M1_Addr(M1_Addr), .M1_WrData(M1_WrData), .M1_RdMem(M1_RdMem), .M1_WrMem(M1_WrMem),
    .M1_RdData(M1_RdData), .M1_RdDone(M1_RdDone), .M1_WrDone(M1_WrDone), .M1_Err(M1_Err),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int slaveMode = 1;
  bit randomSlave = 0;
  logic [31:0] slaveRdData = '0;
  bit pendActive = 0, pendWr = 0;
  int pendCyc = 0;

  // Reference model: per-master request slots plus one outstanding access.
  bit sValid[2], sWr[2];
  logic [ADDR_HI:2] sAddr[2];
  logic [31:0] sData[2];
  bit busy = 0, bWr = 0, lastG = 1;
  int who = 0, issueCyc = 0;
  logic [7:0] ePulse = '0;
  logic [ADDR_HI:2] eAddr = '0;
  logic [31:0] eWd = '0;
  logic [31:0] eRd[2];

  function automatic logic [VW-1:0] dutVec();
    return {M0_RdDone, M0_WrDone, M0_Err, M1_RdDone, M1_WrDone, M1_Err, VMERdMem, VMEWrMem,
            VMEAddr, VMEWrData, M0_RdData, M1_RdData};
  endfunction

  function automatic logic [VW-1:0] expVec();
    return {ePulse, eAddr, eWd, eRd[0], eRd[1]};
  endfunction

  // Consumes this cycle's inputs and predicts the outputs of the next cycle.
  task automatic modelStep();
    bit rd[2], wr[2], empty[2], match, err;
    logic [ADDR_HI:2] a[2];
    logic [31:0] d[2];
    rd[0] = M0_RdMem; wr[0] = M0_WrMem; a[0] = M0_Addr; d[0] = M0_WrData;
    rd[1] = M1_RdMem; wr[1] = M1_WrMem; a[1] = M1_Addr; d[1] = M1_WrData;
    ePulse = 8'h00;
    if (Rst) begin
      for (int i = 0; i < 2; i++) begin
        sValid[i] = 0; sWr[i] = 0; sAddr[i] = '0; sData[i] = '0; eRd[i] = '0;
      end
      busy = 0; lastG = 1; eAddr = '0; eWd = '0;
      return;
    end
    empty[0] = !sValid[0];
    empty[1] = !sValid[1];
    if (!busy) begin
      if (sValid[0] || sValid[1]) begin
        who = (sValid[0] && sValid[1]) ? (lastG ? 0 : 1) : (sValid[1] ? 1 : 0);
        busy = 1; bWr = sWr[who]; issueCyc = cyc + 1;
        eAddr = sAddr[who]; eWd = sData[who];
        if (bWr) ePulse[0] = 1'b1; else ePulse[1] = 1'b1;
      end
    end else begin
      match = bWr ? VMEWrDone : VMERdDone;
      if (match || (cyc - issueCyc == TIMEOUT)) begin
        err = !match;
        ePulse[7-3*who] = !bWr;
        ePulse[6-3*who] = bWr;
        ePulse[5-3*who] = err;
        if (!bWr) eRd[who] = err ? 32'h0 : VMERdData;
        sValid[who] = 0; lastG = (who == 1); busy = 0;
      end
    end
    for (int i = 0; i < 2; i++)
      if (empty[i] && (rd[i] || wr[i])) begin
        sValid[i] = 1; sWr[i] = wr[i]; sAddr[i] = a[i]; sData[i] = wr[i] ? d[i] : 32'h0;
      end
  endtask

  // Advance one cycle; also plays the slave, answering each strobe after a chosen delay.
  task automatic tick();
    int dly;
    modelStep();
    @(posedge Clk); #1; cyc++;
    M0_RdMem = 0; M0_WrMem = 0; M1_RdMem = 0; M1_WrMem = 0; M0_WrData = '0; M1_WrData = '0;
    VMERdDone = 0; VMEWrDone = 0; VMERdData = $urandom;
    if (VMERdMem || VMEWrMem) begin
      pendWr = VMEWrMem;
      if (randomSlave) begin
        if ($urandom_range(0, 15) == 0) dly = -1; else dly = int'($urandom_range(0, 4));
        slaveRdData = $urandom;
      end else dly = slaveMode;
      pendActive = (dly >= 0);
      pendCyc = cyc + dly;
    end
    if (pendActive && cyc == pendCyc) begin
      if (pendWr) VMEWrDone = 1;
      else begin VMERdDone = 1; VMERdData = slaveRdData; end
      pendActive = 0;
    end else if (randomSlave && $urandom_range(0, 7) == 0) begin
      if (pendWr) VMERdDone = 1; else VMEWrDone = 1;
    end
  endtask

  task automatic test_reset();
    Rst = 1;
    tick();
    if (dutVec() !== expVec()) begin errors++; $display("[TB] FAIL reset_model cyc=%0d got=%h exp=%h", cyc, dutVec(), expVec()); end
    checks++;
    if (dutVec() !== '0) begin errors++; $display("[TB] FAIL reset_values got=%h exp=0", dutVec()); end
    checks++;
    tick();
    Rst = 0;
  endtask

  task automatic test_write_basic();
    int t0, wrCyc = -1, doneCyc = -1, nDone = 0;
    bit errSeen = 0;
    logic [ADDR_HI:2] aSeen = '0;
    logic [31:0] dSeen = '0;
    slaveMode = 1;
    t0 = cyc;
    M0_Addr = AW'(1); M0_WrData = 32'hA5A5A5A5; M0_WrMem = 1;
    repeat (8) begin
      tick();
      if (dutVec() !== expVec()) begin errors++; $display("[TB] FAIL write_model cyc=%0d got=%h exp=%h", cyc, dutVec(), expVec()); end
      checks++;
      if (VMEWrMem) begin wrCyc = cyc - t0; aSeen = VMEAddr; dSeen = VMEWrData; end
      if (M0_WrDone) begin doneCyc = cyc - t0; nDone++; end
      if (M0_Err) errSeen = 1;
    end
    if (wrCyc !== 2) begin errors++; $display("[TB] FAIL write_strobe_cycle got=%0d exp=2", wrCyc); end
    checks++;
    if (aSeen !== AW'(1) || dSeen !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL write_addr_data got=%h/%h exp=1/a5a5a5a5", aSeen, dSeen); end
    checks++;
    if (doneCyc !== 4 || nDone !== 1) begin errors++; $display("[TB] FAIL write_done got cyc=%0d n=%0d exp cyc=4 n=1", doneCyc, nDone); end
    checks++;
    if (errSeen !== 0) begin errors++; $display("[TB] FAIL write_err got=1 exp=0"); end
    checks++;
  endtask

  task automatic test_round_robin();
    int order[$];
    Rst = 1;
    tick();
    Rst = 0;
    slaveMode = 0; slaveRdData = 32'hCAFE0001;
    // A lone M0 access between the two pairs leaves M0 as last grant, so M1 wins the second tie.
    for (int p = 0; p < 3; p++) begin
      M0_RdMem = 1; M0_Addr = AW'(3);
      if (p != 1) begin M1_WrMem = 1; M1_Addr = AW'(4); M1_WrData = 32'h0BADF00D; end
      repeat (8) begin
        tick();
        if (dutVec() !== expVec()) begin errors++; $display("[TB] FAIL rr_model cyc=%0d got=%h exp=%h", cyc, dutVec(), expVec()); end
        checks++;
        if (M0_RdDone || M0_WrDone) order.push_back(0);
        if (M1_RdDone || M1_WrDone) order.push_back(1);
      end
    end
    if (order.size() != 5 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1 || order[4] != 0) begin
      errors++; $display("[TB] FAIL rr_order got=%p exp='{0,1,0,1,0}", order);
    end
    checks++;
  endtask

  task automatic test_read_delay();
    int t0, n = 0, doneCyc = -1, m0Bad = 0;
    slaveMode = 2; slaveRdData = 32'h12345678;
    t0 = cyc;
    M1_RdMem = 1; M1_Addr = AW'(8'h5A);
    repeat (10) begin
      tick();
      if (dutVec() !== expVec()) begin errors++; $display("[TB] FAIL read_model cyc=%0d got=%h exp=%h", cyc, dutVec(), expVec()); end
      checks++;
      if (M1_RdDone) begin
        n++; doneCyc = cyc - t0;
        if (M1_RdData !== 32'h12345678) begin errors++; $display("[TB] FAIL read_data got=%h exp=12345678", M1_RdData); end
        checks++;
      end
      if (M0_RdDone || M0_WrDone || M0_Err) m0Bad++;
    end
    if (n !== 1 || doneCyc !== 5) begin errors++; $display("[TB] FAIL read_done got n=%0d cyc=%0d exp n=1 cyc=5", n, doneCyc); end
    checks++;
    if (m0Bad !== 0) begin errors++; $display("[TB] FAIL read_m0_idle got=%0d exp=0", m0Bad); end
    checks++;
  endtask

  task automatic test_timeout();
    int n = 0, bad = 0, t0, wrCyc = -1, nWr = 0;
    logic [31:0] rdAt = 32'hFFFFFFFF;
    slaveMode = -1;
    M0_RdMem = 1; M0_Addr = AW'(7);
    repeat (TIMEOUT + 8) begin
      tick();
      if (dutVec() !== expVec()) begin errors++; $display("[TB] FAIL timeout_model cyc=%0d got=%h exp=%h", cyc, dutVec(), expVec()); end
      checks++;
      if (M0_RdDone && M0_Err) begin n++; rdAt = M0_RdData; end
      if (M0_RdDone !== M0_Err) bad++;
    end
    if (n !== 1 || bad !== 0) begin errors++; $display("[TB] FAIL timeout_pulse got n=%0d bad=%0d exp n=1 bad=0", n, bad); end
    checks++;
    if (rdAt !== 32'h0) begin errors++; $display("[TB] FAIL timeout_rddata got=%h exp=0", rdAt); end
    checks++;
    slaveMode = 1; t0 = cyc;
    M0_WrMem = 1; M0_Addr = AW'(9); M0_WrData = 32'h600DD00D;
    repeat (8) begin
      tick();
      if (dutVec() !== expVec()) begin errors++; $display("[TB] FAIL after_timeout_model cyc=%0d got=%h exp=%h", cyc, dutVec(), expVec()); end
      checks++;
      if (VMEWrMem) wrCyc = cyc - t0;
      if (M0_WrDone && !M0_Err) nWr++;
    end
    if (wrCyc !== 2 || nWr !== 1) begin errors++; $display("[TB] FAIL after_timeout got strobe=%0d done=%0d exp 2/1", wrCyc, nWr); end
    checks++;
  endtask

  task automatic test_busy_strobe();
    int nWr = 0, nDone = 0;
    logic [ADDR_HI:2] aSeen = '0;
    slaveMode = 3;
    M0_WrMem = 1; M0_Addr = AW'(8'h11); M0_WrData = 32'h11111111;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (dutVec() !== expVec()) begin errors++; $display("[TB] FAIL busy_model cyc=%0d got=%h exp=%h", cyc, dutVec(), expVec()); end
      checks++;
      if (VMEWrMem) begin nWr++; aSeen = VMEAddr; end
      if (M0_WrDone) nDone++;
      if (k <= 5) begin M0_WrMem = 1; M0_Addr = AW'(8'h22); M0_WrData = 32'h22222222; end
    end
    if (nWr !== 1 || aSeen !== AW'(8'h11)) begin errors++; $display("[TB] FAIL busy_issue got n=%0d addr=%h exp n=1 addr=11", nWr, aSeen); end
    checks++;
    if (nDone !== 1) begin errors++; $display("[TB] FAIL busy_done got=%0d exp=1", nDone); end
    checks++;
  endtask

  task automatic test_reset_mid_access();
    slaveMode = 6;
    M0_WrMem = 1; M0_Addr = AW'(8'h33); M0_WrData = 32'h33333333;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (dutVec() !== expVec()) begin errors++; $display("[TB] FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, dutVec(), expVec()); end
      checks++;
      if (k >= 5) begin
        if (dutVec() !== '0) begin errors++; $display("[TB] FAIL rstmid_quiet cyc=%0d got=%h exp=0", cyc, dutVec()); end
        checks++;
      end
      if (k == 4) Rst = 1;
      if (k == 5) Rst = 0;
    end
  endtask

  task automatic test_random();
    int sel;
    randomSlave = 1;
    repeat (600) begin
      tick();
      if (dutVec() !== expVec()) begin errors++; $display("[TB] FAIL random_model cyc=%0d got=%h exp=%h", cyc, dutVec(), expVec()); end
      checks++;
      if ($urandom_range(0, 2) == 0) begin
        sel = int'($urandom_range(0, 2));
        M0_Addr = AW'($urandom);
        M0_RdMem = (sel != 1); M0_WrMem = (sel != 0);
        if (sel != 0) M0_WrData = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        sel = int'($urandom_range(0, 2));
        M1_Addr = AW'($urandom);
        M1_RdMem = (sel != 1); M1_WrMem = (sel != 0);
        if (sel != 0) M1_WrData = $urandom;
      end
    end
    randomSlave = 0; slaveMode = 1;
    repeat (40) begin
      tick();
      if (dutVec() !== expVec()) begin errors++; $display("[TB] FAIL drain_model cyc=%0d got=%h exp=%h", cyc, dutVec(), expVec()); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_round_robin();
    test_read_delay();
    test_timeout();
    test_busy_strobe();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
